// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_pkg
//  Purpose  : Opcode map and sequencing-state encoding for alu_exec_unit.
//  Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

  // Opcode map; every value not listed here decodes as illegal.
  localparam int unsigned OP_TRAP  = 0;
  localparam int unsigned OP_NOP   = 1;
  localparam int unsigned OP_NOT   = 8;
  localparam int unsigned OP_AND   = 9;
  localparam int unsigned OP_OR    = 10;
  localparam int unsigned OP_XOR   = 11;
  localparam int unsigned OP_SHFTR = 12;
  localparam int unsigned OP_SHFTL = 13;
  localparam int unsigned OP_ROTR  = 14;
  localparam int unsigned OP_ROTL  = 15;
  localparam int unsigned OP_SWAP  = 16;
  localparam int unsigned OP_INC   = 17;
  localparam int unsigned OP_DEC   = 18;
  localparam int unsigned OP_ADD   = 19;
  localparam int unsigned OP_ADDC  = 20;
  localparam int unsigned OP_SUB   = 21;
  localparam int unsigned OP_EQ    = 22;
  localparam int unsigned OP_GT    = 23;
  localparam int unsigned OP_LT    = 24;

  // Sequencing state: normal issue, second SWAP write pending, halted by TRAP.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SWAP2 = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_shift_rot.sv
`default_nettype none
// ============================================================================
//  Module   : alu_shift_rot
//  Purpose  : Combinational logical shifter / rotator.
//             dir=0 right, dir=1 left; rot=1 selects rotate.
//             Shifts by amt>=WIDTH give 0; rotates use amt mod WIDTH.
//  Revision : 1.0  initial release
// ============================================================================
module alu_shift_rot #(
  parameter int WIDTH = 20
) (
  input  logic [WIDTH-1:0]         a,
  input  logic [$clog2(WIDTH)-1:0] amt,
  input  logic                     dir,
  input  logic                     rot,
  output logic [WIDTH-1:0]         y
);

  int unsigned        amt_u;
  int unsigned        rot_amt;
  logic [2*WIDTH-1:0] dbl;
  logic [2*WIDTH-1:0] dbl_r;
  logic [2*WIDTH-1:0] dbl_l;

  // Rotates are taken from a doubled copy of the operand so wrap-around bits fall out naturally.
  always_comb begin
    amt_u   = 32'(amt);
    rot_amt = amt_u % 32'(WIDTH);
    dbl     = {a, a};
    dbl_r   = dbl >> rot_amt;
    dbl_l   = dbl << rot_amt;
    y       = '0;
    if (rot) begin
      y = dir ? dbl_l[2*WIDTH-1:WIDTH] : dbl_r[WIDTH-1:0];
    end else if (amt_u < 32'(WIDTH)) begin
      y = dir ? (a << amt_u) : (a >> amt_u);
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_exec_unit
//  Purpose  : Registered single-stage execute unit with valid/ready on both
//             sides, persistent carry for ADDC, two-write SWAP sequencing
//             and a sticky halting TRAP.
//  Revision : 1.0  initial release
// ============================================================================
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 20,
  parameter int OPW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_w,
  output logic             out_wsel,
  output logic             out_we,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_sign,
  output logic             out_illegal,
  output logic             trap
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state;
  state_t           state_next;
  logic             c_q;
  logic [WIDTH-1:0] swap_a;

  logic             accept;
  logic             drain;
  logic [31:0]      op_ext;

  logic [WIDTH:0]   sum_add;
  logic [WIDTH:0]   sum_addc;
  logic [WIDTH:0]   sum_inc;
  logic [WIDTH:0]   diff_sub;
  logic [WIDTH:0]   diff_dec;
  logic [WIDTH-1:0] shift_y;
  logic             shift_dir;
  logic             shift_rot;

  logic [WIDTH-1:0] res;
  logic             res_we;
  logic             res_carry;
  logic             res_illegal;
  logic             res_arith;

  // While the second SWAP write is pending no new bundle may enter.
  assign in_ready = (state == ST_RUN) && !(out_valid && out_wsel) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign drain    = out_valid && out_ready;
  assign op_ext   = 32'(in_op);

  // Extra top bit of each sum/difference is the carry-out or borrow.
  assign sum_add  = {1'b0, in_a} + {1'b0, in_b};
  assign sum_addc = sum_add + {{WIDTH{1'b0}}, c_q};
  assign sum_inc  = {1'b0, in_a} + {{WIDTH{1'b0}}, 1'b1};
  assign diff_sub = {1'b0, in_a} - {1'b0, in_b};
  assign diff_dec = {1'b0, in_a} - {{WIDTH{1'b0}}, 1'b1};

  assign shift_dir = (op_ext == OP_SHFTL) || (op_ext == OP_ROTL);
  assign shift_rot = (op_ext == OP_ROTR)  || (op_ext == OP_ROTL);

  alu_shift_rot #(
    .WIDTH (WIDTH)
  ) u_shift_rot (
    .a   (in_a),
    .amt (in_b[SHW-1:0]),
    .dir (shift_dir),
    .rot (shift_rot),
    .y   (shift_y)
  );

  // Opcode decode and result selection for the incoming bundle.
  always_comb begin
    res         = '0;
    res_we      = 1'b0;
    res_carry   = 1'b0;
    res_illegal = 1'b0;
    res_arith   = 1'b0;
    case (op_ext)
      OP_TRAP, OP_NOP: ;
      OP_NOT:   begin res = ~in_a;        res_we = 1'b1; end
      OP_AND:   begin res = in_a & in_b;  res_we = 1'b1; end
      OP_OR:    begin res = in_a | in_b;  res_we = 1'b1; end
      OP_XOR:   begin res = in_a ^ in_b;  res_we = 1'b1; end
      OP_SHFTR, OP_SHFTL, OP_ROTR, OP_ROTL:
                begin res = shift_y;      res_we = 1'b1; end
      OP_SWAP:  begin res = in_b;         res_we = 1'b1; end
      OP_INC:   begin res = sum_inc[WIDTH-1:0];  res_carry = sum_inc[WIDTH];  res_we = 1'b1; res_arith = 1'b1; end
      OP_DEC:   begin res = diff_dec[WIDTH-1:0]; res_carry = diff_dec[WIDTH]; res_we = 1'b1; res_arith = 1'b1; end
      OP_ADD:   begin res = sum_add[WIDTH-1:0];  res_carry = sum_add[WIDTH];  res_we = 1'b1; res_arith = 1'b1; end
      OP_ADDC:  begin res = sum_addc[WIDTH-1:0]; res_carry = sum_addc[WIDTH]; res_we = 1'b1; res_arith = 1'b1; end
      OP_SUB:   begin res = diff_sub[WIDTH-1:0]; res_carry = diff_sub[WIDTH]; res_we = 1'b1; res_arith = 1'b1; end
      OP_EQ:    begin res = {{(WIDTH-1){1'b0}}, in_a == in_b}; res_we = 1'b1; end
      OP_GT:    begin res = {{(WIDTH-1){1'b0}}, in_a >  in_b}; res_we = 1'b1; end
      OP_LT:    begin res = {{(WIDTH-1){1'b0}}, in_a <  in_b}; res_we = 1'b1; end
      default:  res_illegal = 1'b1;
    endcase
  end

  // Next-state logic: SWAP takes two output handshakes, TRAP halts until reset.
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (accept && op_ext == OP_TRAP)      state_next = ST_HALT;
        else if (accept && op_ext == OP_SWAP) state_next = ST_SWAP2;
      end
      ST_SWAP2: if (drain) state_next = ST_RUN;
      ST_HALT:  state_next = ST_HALT;
      default:  state_next = ST_RUN;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_RUN;
    else     state <= state_next;
  end

  // Output register, carry register, SWAP latch and sticky trap.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_w       <= '0;
      out_wsel    <= 1'b0;
      out_we      <= 1'b0;
      out_carry   <= 1'b0;
      out_zero    <= 1'b0;
      out_sign    <= 1'b0;
      out_illegal <= 1'b0;
      c_q         <= 1'b0;
      swap_a      <= '0;
      trap        <= 1'b0;
    end else if (state == ST_SWAP2) begin
      if (drain) begin
        out_w       <= swap_a;
        out_wsel    <= 1'b1;
        out_we      <= 1'b1;
        out_carry   <= 1'b0;
        out_zero    <= (swap_a == '0);
        out_sign    <= swap_a[WIDTH-1];
        out_illegal <= 1'b0;
      end
    end else if (accept) begin
      out_valid   <= 1'b1;
      out_w       <= res;
      out_wsel    <= 1'b0;
      out_we      <= res_we;
      out_carry   <= res_carry;
      out_zero    <= (res == '0);
      out_sign    <= res[WIDTH-1];
      out_illegal <= res_illegal;
      if (res_arith)            c_q    <= res_carry;
      if (op_ext == OP_SWAP)    swap_a <= in_a;
      if (op_ext == OP_TRAP)    trap   <= 1'b1;
    end else if (drain) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_exec_unit
//  Purpose  : Directed self-checking bench for alu_exec_unit (WIDTH=20).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int WIDTH = 20;
  localparam int OPW   = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_w;
  logic             out_wsel;
  logic             out_we;
  logic             out_carry;
  logic             out_zero;
  logic             out_sign;
  logic             out_illegal;
  logic             trap;

  int tests = 0;
  int fails = 0;

  alu_exec_unit #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_w(out_w), .out_wsel(out_wsel),
    .out_we(out_we), .out_carry(out_carry), .out_zero(out_zero), .out_sign(out_sign),
    .out_illegal(out_illegal), .trap(trap)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Compares the whole registered output bundle, expecting out_valid=1.
  task automatic chk_out(input string tag, input logic [WIDTH-1:0] w, input logic wsel,
                         input logic we, input logic c, input logic z, input logic s, input logic ill);
    chk(tag, 64'({out_valid, out_w, out_wsel, out_we, out_carry, out_zero, out_sign, out_illegal}),
             64'({1'b1, w, wsel, we, c, z, s, ill}));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic issue(input int unsigned op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    int n;
    n = 0;
    in_op = OPW'(op); in_a = a; in_b = b; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) begin
      tests++; fails++;
      $error("FAIL issue_timeout observed=in_ready_low expected=accept op=%0d", op);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [WIDTH-1:0] expq[$];
  int sent, recvd, ncyc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b0;
    cyc(2);
    rst = 1'b0;
    chk("reset_outputs", 64'({out_valid, out_w, out_wsel, out_we, out_carry, out_zero,
                              out_sign, out_illegal, trap}), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(1));

    // Carry chain: ADD sets c_q, ADDC consumes it.
    issue(OP_ADD, 20'hFFFFF, 20'h00001);  chk_out("add_wrap", 20'h00000, 0, 1, 1, 1, 0, 0);  drain();
    chk("drained_valid", 64'(out_valid), 64'(0));
    issue(OP_ADDC, 20'h00001, 20'h00001); chk_out("addc",     20'h00003, 0, 1, 0, 0, 0, 0);  drain();
    issue(OP_SUB, 20'h00003, 20'h00005);  chk_out("sub_borrow", 20'hFFFFE, 0, 1, 1, 0, 1, 0); drain();
    issue(OP_DEC, 20'h00000, 20'h00000);  chk_out("dec_zero", 20'hFFFFF, 0, 1, 1, 0, 1, 0);  drain();
    // XOR must keep c_q=1 from DEC, so ADDC 0+0 yields 1.
    issue(OP_XOR, 20'hF0F0F, 20'h0FFFF);  chk_out("xor",      20'hFF0F0, 0, 1, 0, 0, 1, 0);  drain();
    issue(OP_ADDC, 20'h00000, 20'h00000); chk_out("addc_keep", 20'h00001, 0, 1, 0, 0, 0, 0); drain();

    // Shifts and rotates.
    issue(OP_ROTL, 20'h80001, 20'h00004);  chk_out("rotl",     20'h00018, 0, 1, 0, 0, 0, 0); drain();
    issue(OP_ROTR, 20'h00001, 20'd21);     chk_out("rotr_mod", 20'h80000, 0, 1, 0, 0, 1, 0); drain();
    issue(OP_SHFTL, 20'h00001, 20'd20);    chk_out("shl_full", 20'h00000, 0, 1, 0, 1, 0, 0); drain();
    issue(OP_SHFTR, 20'h80000, 20'd19);    chk_out("shr",      20'h00001, 0, 1, 0, 0, 0, 0); drain();

    // Compares and NOP.
    issue(OP_EQ, 20'h00005, 20'h00005);    chk_out("eq",  20'h00001, 0, 1, 0, 0, 0, 0); drain();
    issue(OP_LT, 20'h00003, 20'h00005);    chk_out("lt",  20'h00001, 0, 1, 0, 0, 0, 0); drain();
    issue(OP_GT, 20'h00003, 20'h00005);    chk_out("gt",  20'h00000, 0, 1, 0, 1, 0, 0); drain();
    issue(OP_NOT, 20'h0F0F0, 20'h12345);   chk_out("not", 20'hF0F0F, 0, 1, 0, 0, 1, 0); drain();
    issue(OP_NOP, 20'h12345, 20'h12345);   chk_out("nop", 20'h00000, 0, 0, 0, 1, 0, 0); drain();

    // Back-to-back ADDs at full throughput.
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_op = OPW'(OP_ADD); in_a = 20'(i * 3); in_b = 20'h00011;
      #1;
      chk("b2b_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk); #1;
      chk("b2b_result", 64'({out_valid, out_w}), 64'({1'b1, 20'(i * 3 + 17)}));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("b2b_drained", 64'(out_valid), 64'(0));

    // Random backpressure: order and values preserved.
    sent = 0; recvd = 0; ncyc = 0;
    while ((sent < 6 || expq.size() != 0) && ncyc < 300) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 6);
      in_op     = OPW'(OP_ADD);
      in_a      = 20'h12345 + 20'(sent * 20'h11111);
      in_b      = 20'h0F0F0;
      #1;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          tests++; fails++;
          $error("FAIL rand_spurious observed=%h expected=no_result", out_w);
        end else begin
          chk("rand_result", 64'(out_w), 64'(expq.pop_front()));
          recvd++;
        end
      end
      if (in_valid && in_ready) begin
        expq.push_back(in_a + in_b);
        sent++;
      end
      @(posedge clk); #1;
      ncyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("rand_count", 64'(recvd), 64'(6));

    // SWAP with backpressure on the first write.
    issue(OP_SWAP, 20'h00AAA, 20'h00555);
    chk_out("swap_first", 20'h00555, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk_out("swap_hold", 20'h00555, 0, 1, 0, 0, 0, 0);
      chk("swap_hold_ready", 64'(in_ready), 64'(0));
    end
    drain();
    chk_out("swap_second", 20'h00AAA, 1, 1, 0, 0, 0, 0);
    in_valid = 1'b1; in_op = OPW'(OP_ADD); out_ready = 1'b1;
    #1;
    chk("swap_second_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("swap_done", 64'({out_valid, in_ready}), 64'({1'b0, 1'b1}));

    // Reset while SWAP2 is pending discards the result.
    issue(OP_SWAP, 20'h00001, 20'h00002);
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("swap_rst", 64'({out_valid, out_w, in_ready}), 64'({1'b0, 20'h0, 1'b1}));

    // TRAP halts the unit until reset.
    issue(OP_TRAP, 20'h00007, 20'h00007);
    chk_out("trap_out", 20'h00000, 0, 0, 0, 1, 0, 0);
    chk("trap_flag", 64'(trap), 64'(1));
    drain();
    in_valid = 1'b1; in_op = OPW'(OP_ADD); out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("halt_blocked", 64'({in_ready, out_valid, trap}), 64'({1'b0, 1'b0, 1'b1}));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b1; cyc(1); rst = 1'b0;
    chk("trap_reset", 64'({out_valid, out_w, out_wsel, out_we, out_carry, out_zero,
                           out_sign, out_illegal, trap, in_ready}), 64'(1));

    // Illegal opcode.
    issue(5, 20'h00123, 20'h00456);
    chk_out("illegal", 20'h00000, 0, 0, 0, 1, 0, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
